// File: rtl/alu_pkg.sv
// Shared definitions for the alu arbiter slice.
//   - alu operator codes and default widths
//   - is_legal_op: true for the six operators the alu implements
//   - arb_state_t: arbiter FSM state encoding
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
      default:                                       is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between the two requesters / external alu (master side) and the
// arbiter (slave side).
//   req_*  : per-requester valid/ready handshake and operands
//   alu_*  : registered operands out to the alu, result/zero back
//   rsp_*  : one-hot response valid, shared result bus, per-requester accept
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [DATA_WIDTH-1:0] req0_first_arg;
  logic [DATA_WIDTH-1:0] req0_second_arg;
  logic [OP_WIDTH-1:0]   req0_operator;
  logic [DATA_WIDTH-1:0] req1_first_arg;
  logic [DATA_WIDTH-1:0] req1_second_arg;
  logic [OP_WIDTH-1:0]   req1_operator;
  logic [DATA_WIDTH-1:0] alu_first_arg;
  logic [DATA_WIDTH-1:0] alu_second_arg;
  logic [OP_WIDTH-1:0]   alu_operator;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;
  logic                  rsp_illegal;

  modport master (
    output req_valid, req0_first_arg, req0_second_arg, req0_operator,
           req1_first_arg, req1_second_arg, req1_operator,
           alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_first_arg, alu_second_arg, alu_operator,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req0_first_arg, req0_second_arg, req0_operator,
           req1_first_arg, req1_second_arg, req1_operator,
           alu_result, alu_zero, rsp_ready,
    output req_ready, alu_first_arg, alu_second_arg, alu_operator,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant.
//   req      : request vector, bit i = requester i
//   advance  : a grant was taken this cycle; pointer moves to the loser
//   grant    : one-hot combinational grant (00 when nothing requested)
//   grant_id : index of the granted requester
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Pointer names the requester that wins when both are asking.
  logic ptr;

  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    case (req)
      2'b01: begin grant_id = 1'b0; grant = 2'b01; end
      2'b10: begin grant_id = 1'b1; grant = 2'b10; end
      2'b11: begin grant_id = ptr;  grant = ptr ? 2'b10 : 2'b01; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= ~grant_id;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational alu between two requesters
// (0 = execute stage, 1 = branch/compare helper). One operation in flight:
// IDLE grants and latches operands, ISSUE lets the alu settle and captures
// the result, RESP holds the response until the owner accepts it.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_arbiter_if slave modport (req_*, alu_*, rsp_*)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  arb_state_t            state;
  logic                  owner;
  logic [1:0]            grant;
  logic                  grant_id;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] sel_first_arg;
  logic [DATA_WIDTH-1:0] sel_second_arg;
  logic [OP_WIDTH-1:0]   sel_operator;

  rr_arbiter_2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req_valid),
    .advance  (handshake),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready only in IDLE and never while reset is held, so a grant seen by a
  // requester always corresponds to a latched operation.
  assign bus.req_ready = (state == ST_IDLE && !reset) ? grant : 2'b00;
  assign handshake     = (state == ST_IDLE) && (grant != 2'b00);

  always_comb begin
    sel_first_arg  = bus.req0_first_arg;
    sel_second_arg = bus.req0_second_arg;
    sel_operator   = bus.req0_operator;
    if (grant_id) begin
      sel_first_arg  = bus.req1_first_arg;
      sel_second_arg = bus.req1_second_arg;
      sel_operator   = bus.req1_operator;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      owner              <= 1'b0;
      bus.rsp_valid      <= 2'b00;
      bus.rsp_result     <= '0;
      bus.rsp_zero       <= 1'b0;
      bus.rsp_illegal    <= 1'b0;
      bus.alu_first_arg  <= '0;
      bus.alu_second_arg <= '0;
      bus.alu_operator   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            bus.alu_first_arg  <= sel_first_arg;
            bus.alu_second_arg <= sel_second_arg;
            bus.alu_operator   <= sel_operator;
            owner              <= grant_id;
            state              <= ST_ISSUE;
          end
        end
        // alu output is valid on the registered operands by this edge.
        ST_ISSUE: begin
          bus.rsp_result  <= bus.alu_result;
          bus.rsp_zero    <= bus.alu_zero;
          bus.rsp_illegal <= !is_legal_op(bus.alu_operator);
          bus.rsp_valid   <= owner ? 2'b10 : 2'b01;
          state           <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[owner]) begin
            bus.rsp_valid <= 2'b00;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External alu model: combinational on the arbiter's registered operands.
  // Unknown operators give result 0 and zero flag 0.
  always_comb begin
    bus.alu_result = '0;
    bus.alu_zero   = 1'b0;
    case (bus.alu_operator)
      OP_AND: bus.alu_result = bus.alu_first_arg & bus.alu_second_arg;
      OP_OR:  bus.alu_result = bus.alu_first_arg | bus.alu_second_arg;
      OP_ADD: bus.alu_result = bus.alu_first_arg + bus.alu_second_arg;
      OP_SUB: bus.alu_result = bus.alu_first_arg - bus.alu_second_arg;
      OP_SLT: bus.alu_result = {31'd0, $signed(bus.alu_first_arg) < $signed(bus.alu_second_arg)};
      OP_NOR: bus.alu_result = ~(bus.alu_first_arg | bus.alu_second_arg);
      default: ;
    endcase
    if (is_legal_op(bus.alu_operator)) bus.alu_zero = (bus.alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_operator   = op;
    bus.req0_first_arg  = a;
    bus.req0_second_arg = b;
  endtask

  task automatic set_req1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_operator   = op;
    bus.req1_first_arg  = a;
    bus.req1_second_arg = b;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    set_req0(OP_ADD, 32'd1, 32'd2);
    set_req1(OP_ADD, 32'd3, 32'd4);

    // ---------------- reset with both requesters valid
    step();
    check("rst_req_ready_c1", bus.req_ready, 2'b00);
    step();
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 2'b00);
    check("rst_alu_op", bus.alu_operator, 4'd0);
    check("rst_alu_a", bus.alu_first_arg, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_zero", bus.rsp_zero, 1'b0);
    check("rst_rsp_illegal", bus.rsp_illegal, 1'b0);

    // ---------------- single request: req0 ADD 5,7
    bus.req_valid = 2'b00;
    step();
    reset         = 1'b0;
    set_req0(OP_ADD, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    #1;
    check("single_ready", bus.req_ready, 2'b01);
    step();                                  // handshake edge
    bus.req_valid = 2'b00;
    check("single_issue_valid", bus.rsp_valid, 2'b00);
    check("single_alu_a", bus.alu_first_arg, 32'd5);
    check("single_alu_b", bus.alu_second_arg, 32'd7);
    check("single_alu_op", bus.alu_operator, OP_ADD);
    check("single_issue_ready", bus.req_ready, 2'b00);
    step();
    check("single_rsp_valid", bus.rsp_valid, 2'b01);
    check("single_result", bus.rsp_result, 32'd12);
    check("single_zero", bus.rsp_zero, 1'b0);
    check("single_illegal", bus.rsp_illegal, 1'b0);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    check("single_done_valid", bus.rsp_valid, 2'b00);
    bus.req_valid = 2'b01;                  // IDLE again: immediate re-grant visible
    set_req0(OP_AND, 32'd0, 32'd0);
    #1;
    check("single_back_idle", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;

    // ---------------- contention from reset
    do_reset();
    set_req0(OP_SUB, 32'd9, 32'd9);
    set_req1(OP_OR, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    #1;
    check("cont_first_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b10;
    step();
    check("cont0_rsp_valid", bus.rsp_valid, 2'b01);
    check("cont0_result", bus.rsp_result, 32'd0);
    check("cont0_zero", bus.rsp_zero, 1'b1);
    check("cont0_resp_ready", bus.req_ready, 2'b00);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    check("cont_second_grant", bus.req_ready, 2'b10);
    step();                                  // handshake req1
    set_req0(OP_AND, 32'hFF, 32'h0F);
    set_req1(OP_NOR, 32'd0, 32'd0);
    bus.req_valid = 2'b11;
    step();
    check("cont1_rsp_valid", bus.rsp_valid, 2'b10);
    check("cont1_result", bus.rsp_result, 32'hFF);
    check("cont1_zero", bus.rsp_zero, 1'b0);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    check("cont_third_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b10;
    step();
    check("cont2_result", bus.rsp_result, 32'h0F);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    check("bp_grant1", bus.req_ready, 2'b10);

    // ---------------- backpressure: req1 NOR 0,0 with owner not accepting
    step();                                  // handshake req1 NOR
    set_req0(OP_ADD, 32'd1, 32'd2);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;                  // non-owner accept must be ignored
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid_%0d", i), bus.rsp_valid, 2'b10);
      check($sformatf("bp_result_%0d", i), bus.rsp_result, 32'hFFFF_FFFF);
      check($sformatf("bp_req0_wait_%0d", i), bus.req_ready, 2'b00);
      step();
    end
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    check("bp_released", bus.rsp_valid, 2'b00);
    check("bp_req0_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    step();
    check("bp_req0_result", bus.rsp_result, 32'd3);
    step();
    bus.rsp_ready = 2'b00;
    check("bp_req0_done", bus.rsp_valid, 2'b00);

    // ---------------- reset during ISSUE (pointer currently favours req1)
    set_req1(OP_SUB, 32'd10, 32'd3);
    bus.req_valid = 2'b10;
    #1;
    check("mid_grant", bus.req_ready, 2'b10);
    step();                                  // handshake, now in ISSUE
    bus.req_valid = 2'b00;
    reset         = 1'b1;
    bus.rsp_ready = 2'b00;
    step();
    check("mid_rst_valid", bus.rsp_valid, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_no_rsp_%0d", i), bus.rsp_valid, 2'b00);
    end
    set_req0(OP_ADD, 32'd2, 32'd2);
    set_req1(OP_ADD, 32'd3, 32'd3);
    bus.req_valid = 2'b11;
    #1;
    check("mid_ptr0_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b10;
    step();
    check("mid_req0_valid", bus.rsp_valid, 2'b01);
    check("mid_req0_result", bus.rsp_result, 32'd4);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    check("mid_req1_grant", bus.req_ready, 2'b10);
    step();
    bus.req_valid = 2'b00;
    step();
    check("mid_req1_result", bus.rsp_result, 32'd6);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;

    // ---------------- illegal operator 0011
    set_req0(4'b0011, 32'd3, 32'd4);
    bus.req_valid = 2'b01;
    #1;
    check("ill_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    step();
    check("ill_valid", bus.rsp_valid, 2'b01);
    check("ill_result", bus.rsp_result, 32'd0);
    check("ill_zero", bus.rsp_zero, 1'b0);
    check("ill_flag", bus.rsp_illegal, 1'b1);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    check("ill_done", bus.rsp_valid, 2'b00);

    // ---------------- legal op after illegal clears the flag (SLT -1 < 1)
    set_req1(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b00;
    step();
    check("slt_valid", bus.rsp_valid, 2'b10);
    check("slt_result", bus.rsp_result, 32'd1);
    check("slt_illegal", bus.rsp_illegal, 1'b0);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
